pipelined_adder_tree: RTL and testbench

//  Parametrised, fully pipelined signed adder tree for the conv engine. It sums N_IN products and,

---
 rtl/pipelined_adder_tree.sv | 148 ++++++++++++++
 tb/tb_pipelined_adder_tree.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_tree.sv
// Fully pipelined signed adder tree with an optional psum or running-accumulator addend.
// Accepts one vector per cycle; results emerge in issue order after LEVELS+1 register stages.
module pipelined_adder_tree #(
  parameter int N_IN   = 9,
  parameter int IN_W   = 25,
  parameter int PSUM_W = 36,
  parameter int OUT_W  = 36
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [N_IN*IN_W-1:0]   in_data,
  input  logic [PSUM_W-1:0]      psum_in,
  input  logic [1:0]             mode,
  input  logic                   acc_clr,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_sum,
  output logic                   out_sat
);

  localparam int LEVELS = $clog2(N_IN);
  localparam int TREE_W = IN_W + LEVELS;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Number of live elements entering tree level k (level 0 = raw products).
  function automatic int level_cnt(input int k);
    int n;
    n = N_IN;
    for (int j = 0; j < k; j++) n = (n + 1) / 2;
    return n;
  endfunction

  localparam int F_W = max3(TREE_W, PSUM_W, OUT_W) + 1;

  localparam logic signed [F_W-1:0] SAT_MAX = {{(F_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [F_W-1:0] SAT_MIN = {{(F_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]      OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]      OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef logic signed [TREE_W-1:0] tval_t;

  // All levels are stored at TREE_W; level k only ever needs IN_W+k bits, so no sum can wrap.
  tval_t                stage_in [LEVELS][N_IN];
  tval_t                lvl_q    [LEVELS][N_IN];
  logic  [LEVELS-1:0]   vld_q;
  logic  [LEVELS-1:0]   clr_q;
  logic  [1:0]          mode_q   [LEVELS];
  logic  [PSUM_W-1:0]   psum_q   [LEVELS];

  logic signed [OUT_W-1:0] acc;
  logic signed [F_W-1:0]   f_tree;
  logic signed [F_W-1:0]   f_add;
  logic signed [F_W-1:0]   f_sum;
  logic [OUT_W-1:0]        sat_sum;
  logic                    sat_flag;
  logic                    fin_valid;
  logic [1:0]              fin_mode;

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      stage_in[0][i] = TREE_W'($signed(in_data[i*IN_W +: IN_W]));
    end
    for (int k = 1; k < LEVELS; k++) begin
      for (int i = 0; i < N_IN; i++) begin
        stage_in[k][i] = lvl_q[k-1][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      clr_q <= '0;
      for (int k = 0; k < LEVELS; k++) begin
        mode_q[k] <= '0;
        psum_q[k] <= '0;
        for (int i = 0; i < N_IN; i++) lvl_q[k][i] <= '0;
      end
    end else begin
      vld_q[0]  <= in_valid;
      clr_q[0]  <= acc_clr;
      mode_q[0] <= mode;
      psum_q[0] <= psum_in;
      for (int k = 1; k < LEVELS; k++) begin
        vld_q[k]  <= vld_q[k-1];
        clr_q[k]  <= clr_q[k-1];
        mode_q[k] <= mode_q[k-1];
        psum_q[k] <= psum_q[k-1];
      end
      for (int k = 0; k < LEVELS; k++) begin
        for (int i = 0; i < N_IN / 2; i++) begin
          if (2 * i + 1 < level_cnt(k))
            lvl_q[k][i] <= stage_in[k][2*i] + stage_in[k][2*i+1];
        end
        // odd leftover rides through the level unchanged
        if (level_cnt(k) % 2 == 1)
          lvl_q[k][level_cnt(k)/2] <= stage_in[k][level_cnt(k)-1];
      end
    end
  end

  assign fin_valid = vld_q[LEVELS-1];
  assign fin_mode  = mode_q[LEVELS-1];

  always_comb begin
    f_tree = F_W'(lvl_q[LEVELS-1][0]);
    f_add  = '0;
    case (fin_mode)
      2'b01:   f_add = F_W'($signed(psum_q[LEVELS-1]));
      2'b10:   if (!clr_q[LEVELS-1]) f_add = F_W'(acc);
      default: f_add = '0;
    endcase
    f_sum = f_tree + f_add;

    sat_sum  = f_sum[OUT_W-1:0];
    sat_flag = 1'b0;
    if (f_sum > SAT_MAX) begin
      sat_sum  = OUT_MAX;
      sat_flag = 1'b1;
    end else if (f_sum < SAT_MIN) begin
      sat_sum  = OUT_MIN;
      sat_flag = 1'b1;
    end
  end

  // acc is written at the same edge as out_sum, so a following mode-10 vector sees it next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
      acc       <= '0;
    end else begin
      out_valid <= fin_valid;
      if (fin_valid) begin
        out_sum <= sat_sum;
        out_sat <= sat_flag;
        if (fin_mode == 2'b10) acc <= sat_sum;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed-vector bench: stimulus pushes hand-computed results into a scoreboard queue,
// an independent monitor pops and compares each out_valid pulse including its latency.
module tb_pipelined_adder_tree;

  localparam int N_IN   = 9;
  localparam int IN_W   = 25;
  localparam int PSUM_W = 36;
  localparam int OUT_W  = 36;
  localparam int LAT    = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic [N_IN*IN_W-1:0] in_data;
  logic [PSUM_W-1:0]    psum_in;
  logic [1:0]           mode;
  logic                 acc_clr;
  logic                 out_valid;
  logic [OUT_W-1:0]     out_sum;
  logic                 out_sat;

  pipelined_adder_tree #(
    .N_IN(N_IN), .IN_W(IN_W), .PSUM_W(PSUM_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .psum_in(psum_in),
    .mode(mode), .acc_clr(acc_clr), .out_valid(out_valid), .out_sum(out_sum), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OUT_W-1:0] sum;
    logic             sat;
    int               t_edge;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_IN*IN_W-1:0] fill(input logic signed [IN_W-1:0] v);
    logic [N_IN*IN_W-1:0] r;
    for (int i = 0; i < N_IN; i++) r[i*IN_W +: IN_W] = v;
    return r;
  endfunction

  function automatic logic [N_IN*IN_W-1:0] ramp();
    logic [N_IN*IN_W-1:0] r;
    for (int i = 0; i < N_IN; i++) r[i*IN_W +: IN_W] = IN_W'(i + 1);
    return r;
  endfunction

  function automatic logic [N_IN*IN_W-1:0] alt();
    logic [N_IN*IN_W-1:0] r;
    for (int i = 0; i < N_IN; i++) r[i*IN_W +: IN_W] = (i % 2 == 1) ? -25'sd1000 : 25'sd300;
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_sum 0x%0h, expected no output (t=%0t)",
                 out_sum, $time);
      end else begin
        e = sb.pop_front();
        check("out_sum", out_sum, e.sum);
        check("out_sat", out_sat, e.sat);
        check("latency", 64'(cyc + 1 - e.t_edge), 64'(LAT));
      end
    end
  end

  task automatic send(input logic [N_IN*IN_W-1:0] d, input logic [PSUM_W-1:0] p,
                      input logic [1:0] m, input logic c,
                      input logic [OUT_W-1:0] es, input logic esat, input bit track);
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    psum_in  = p;
    mode     = m;
    acc_clr  = c;
    if (track) begin
      e.sum    = es;
      e.sat    = esat;
      e.t_edge = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; psum_in = '0; mode = 2'b00; acc_clr = 1'b0;
    idle(3);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_sum",   64'(out_sum),   64'd0);
    check("reset_out_sat",   64'(out_sat),   64'd0);
    rst = 1'b0;
    idle(2);

    // single vector, tree only, then hold check
    send(fill(1), '0, 2'b00, 1'b0, 36'd9, 1'b0, 1'b1);
    drain();
    check("hold_out_sum", 64'(out_sum), 64'd9);
    check("hold_out_valid", 64'(out_valid), 64'd0);

    // tree + psum, back to back
    send(fill(-1), 36'd100, 2'b01, 1'b0, 36'd91, 1'b0, 1'b1);
    send(fill(-1), -36'sd5, 2'b01, 1'b0, -36'sd14, 1'b0, 1'b1);
    drain();

    // three consecutive tree-only vectors
    send(fill(2), '0, 2'b00, 1'b0, 36'd18, 1'b0, 1'b1);
    send(fill(3), '0, 2'b00, 1'b0, 36'd27, 1'b0, 1'b1);
    send(fill(4), '0, 2'b00, 1'b0, 36'd36, 1'b0, 1'b1);
    drain();

    // accumulator chaining, interleaved mode-01 vector leaves acc alone
    send(fill(1), '0, 2'b10, 1'b1, 36'd9,  1'b0, 1'b1);
    send(fill(1), '0, 2'b10, 1'b0, 36'd18, 1'b0, 1'b1);
    send(fill(1), '0, 2'b10, 1'b0, 36'd27, 1'b0, 1'b1);
    send(fill(1), '0, 2'b01, 1'b0, 36'd9,  1'b0, 1'b1);
    idle(2);
    send(fill(1), '0, 2'b10, 1'b0, 36'd36, 1'b0, 1'b1);
    drain();

    // reserved mode, ignored acc_clr, distinct and mixed-sign elements (odd leftover matters)
    send(fill(1), 36'd100, 2'b11, 1'b0, 36'd9,  1'b0, 1'b1);
    send(fill(1), 36'd10,  2'b01, 1'b1, 36'd19, 1'b0, 1'b1);
    send(ramp(),  '0,      2'b00, 1'b0, 36'd45, 1'b0, 1'b1);
    send(alt(),   '0,      2'b00, 1'b0, -36'sd2500, 1'b0, 1'b1);
    send(fill(1), '0,      2'b10, 1'b0, 36'd45, 1'b0, 1'b1);
    drain();

    // saturation at both rails
    send(fill({1'b0, {24{1'b1}}}), {1'b0, {35{1'b1}}}, 2'b01, 1'b0,
         {1'b0, {35{1'b1}}}, 1'b1, 1'b1);
    send(fill({1'b1, 24'd0}), {1'b1, 35'd0}, 2'b01, 1'b0,
         {1'b1, 35'd0}, 1'b1, 1'b1);
    drain();

    // reset while a vector is in flight and acc holds 45
    send(fill(5), '0, 2'b00, 1'b0, 36'd45, 1'b0, 1'b0);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("post_reset_out_sum",   64'(out_sum),   64'd0);
    check("post_reset_out_sat",   64'(out_sat),   64'd0);
    check("post_reset_out_valid", 64'(out_valid), 64'd0);
    idle(8);
    send(fill(1), '0, 2'b10, 1'b0, 36'd9, 1'b0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
